output_sram_arbiter: RTL

OUTPUT_SRAM_ARBITER -- requirements
Module: output_sram_arbiter

---
 rtl/output_sram_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/output_sram_arbiter.sv
// output_sram_arbiter: round-robin arbiter from vertex-buffer banks into the output SRAM, with stream sos/eos tracking
module output_sram_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int NODE_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        bank_req,
    input  logic [NUM_REQ*DATA_W-1:0] bank_data,
    input  logic [NUM_REQ*NODE_W-1:0] bank_node_id,
    input  logic [NUM_REQ-1:0]        bank_sos,
    input  logic [NUM_REQ-1:0]        bank_eos,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic                      sram_wen,
    output logic [NODE_W-1:0]         sram_addr,
    output logic [DATA_W-1:0]         sram_wdata,
    output logic                      stream_done,
    output logic                      busy
);
    localparam int PTR_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [NUM_REQ-1:0] r_eos_seen;
    logic               w_xfer;
    logic [PTR_W-1:0]   w_gidx;
    logic               w_sos;
    logic               w_eos;
    logic [NUM_REQ-1:0] w_eos_nxt;

    // first requester at or after rr_ptr, wrapping; grant is suppressed while reset is held
    always_comb begin
        w_xfer = 1'b0;
        w_gidx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_xfer && bank_req[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_xfer = 1'b1;
                w_gidx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
        w_xfer = w_xfer & ~reset;
    end

    assign req_grant   = w_xfer ? NUM_REQ'(1) << w_gidx : '0;
    assign w_sos       = w_xfer & bank_sos[w_gidx];
    assign w_eos       = w_xfer & bank_eos[w_gidx];
    assign w_eos_nxt   = (w_sos ? '0 : r_eos_seen) | (w_eos ? req_grant : '0);
    assign stream_done = r_state == DONE;
    assign busy        = (r_state != IDLE) | sram_wen;

    // rotate the priority pointer past the bank just granted
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_rr_ptr <= '0;
        else if (w_xfer)
            r_rr_ptr <= w_gidx == PTR_W'(NUM_REQ - 1) ? '0 : w_gidx + 1'b1;
    end

    // one-cycle write pipeline; address and data hold when nothing is transferred
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_wen   <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            sram_wen <= w_xfer;
            if (w_xfer) begin
                sram_addr  <= bank_node_id[w_gidx*NODE_W +: NODE_W];
                sram_wdata <= bank_data[w_gidx*DATA_W +: DATA_W];
            end
        end
    end

    // stream FSM: sos (re)starts collection of eos per bank, DONE lasts one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_eos_seen <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_sos) begin
                    r_eos_seen <= w_eos_nxt;
                    r_state    <= &w_eos_nxt ? DONE : ACTIVE;
                end
                ACTIVE: if (w_xfer) begin
                    r_eos_seen <= w_eos_nxt;
                    if (&w_eos_nxt) r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
